// File: rtl/cond_unit.sv
// cond_unit: conditional-execution unit for the single-cycle core.
//
// Holds the architectural {N,Z,C,V} flag register. Decodes the 4-bit
// condition of the current instruction against it, and gates flag writes
// on the result. An optional IT sequencer predicates up to IT_DEPTH
// following instructions with a then/else pattern.
//
// Optional feature macro: COND_IT_EN
//   defined   : the IT sequencer (IDLE/ACTIVE FSM) is built.
//   undefined : there is no sequencer. InIt and ItRemaining read 0, and
//               every ItStart is an illegal request (ItErr pulse,
//               CondEx = 0).
//
// Handshake: there is no valid/ready flow control. InstrValid qualifies
// every state update for the cycle it is high. CondEx is a zero-latency
// combinational answer for the instruction presented in the same cycle.
//
// Ports:
//   clk, reset_n     clock; synchronous active-low reset
//   InstrValid       an instruction executes this cycle
//   Cond             condition field (ignored inside an IT block)
//   ALUFlags         {N,Z,C,V} produced by the current instruction
//   FlagW            [1]: write N,Z   [0]: write C,V
//   ItStart          the current instruction is an IT instruction
//   ItCond           base condition of the IT block
//   ItLen            number of predicated instructions, 1..IT_DEPTH
//   ItPattern        bit i: 1 = instruction i uses ItCond, 0 = the inverse
//   CondEx           the current instruction executes (combinational)
//   Flags            registered {N,Z,C,V}
//   InIt             the sequencer is ACTIVE (doubles as the FSM state view)
//   ItRemaining      predicated instructions left, including the current one
//   ItErr            one-cycle registered pulse for an illegal IT request

module cond_unit #(
    parameter int IT_DEPTH = 4,
    parameter int LEN_W    = $clog2(IT_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                InstrValid,
    input  logic [3:0]          Cond,
    input  logic [3:0]          ALUFlags,
    input  logic [1:0]          FlagW,
    input  logic                ItStart,
    input  logic [3:0]          ItCond,
    input  logic [LEN_W-1:0]    ItLen,
    input  logic [IT_DEPTH-1:0] ItPattern,
    output logic                CondEx,
    output logic [3:0]          Flags,
    output logic                InIt,
    output logic [LEN_W-1:0]    ItRemaining,
    output logic                ItErr
);

    // Condition decode against {N,Z,C,V}. Code 1111 is defined as 0.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: cond_ok = z;
            4'b0001: cond_ok = !z;
            4'b0010: cond_ok = cy;
            4'b0011: cond_ok = !cy;
            4'b0100: cond_ok = n;
            4'b0101: cond_ok = !n;
            4'b0110: cond_ok = v;
            4'b0111: cond_ok = !v;
            4'b1000: cond_ok = cy & !z;
            4'b1001: cond_ok = !(cy & !z);
            4'b1010: cond_ok = (n == v);
            4'b1011: cond_ok = (n != v);
            4'b1100: cond_ok = !z & (n == v);
            4'b1101: cond_ok = !(!z & (n == v));
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    endfunction

    logic [3:0] flags_q, flags_d;
    logic       it_err_q, it_err_d;
    logic [3:0] eff_cond;
    logic       cond_ex;
    logic       flag_we;

`ifdef COND_IT_EN
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } it_state_e;

    it_state_e             state_q, state_d;
    logic [3:0]            base_q, base_d;
    logic [IT_DEPTH-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic                  len_ok;

    assign len_ok = (ItLen != '0) && (ItLen <= LEN_W'(IT_DEPTH));

    // pat_q[0] always belongs to the instruction currently being predicated.
    assign eff_cond = (state_q == ACTIVE) ? (pat_q[0] ? base_q : (base_q ^ 4'b0001))
                                          : Cond;

    // An IT instruction issued from IDLE is unconditional, even when illegal.
    // A nested ItStart in ACTIVE is still a predicated slot.
    assign cond_ex = ((state_q == IDLE) && ItStart) ? 1'b1 : cond_ok(eff_cond, flags_q);

    assign it_err_d = InstrValid & ItStart & ((state_q == ACTIVE) | ~len_ok);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        pat_d   = pat_q;
        rem_d   = rem_q;
        if (InstrValid) begin
            case (state_q)
                IDLE: begin
                    if (ItStart && len_ok) begin
                        state_d = ACTIVE;
                        base_d  = ItCond;
                        pat_d   = ItPattern | IT_DEPTH'(1);
                        rem_d   = ItLen;
                    end
                end
                ACTIVE: begin
                    pat_d = pat_q >> 1;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            pat_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            pat_q   <= pat_d;
            rem_q   <= rem_d;
        end
    end

    assign InIt        = (state_q == ACTIVE);
    assign ItRemaining = rem_q;
`else
    // Without the sequencer the IT operand inputs carry no meaning.
    logic unused_it_inputs;
    assign unused_it_inputs = ^{ItCond, ItLen, ItPattern};

    assign eff_cond    = Cond;
    assign cond_ex     = ItStart ? 1'b0 : cond_ok(eff_cond, flags_q);
    assign it_err_d    = InstrValid & ItStart;
    assign InIt        = 1'b0;
    assign ItRemaining = '0;
`endif

    // IT instructions never write flags, legal or not.
    assign flag_we = InstrValid & cond_ex & ~ItStart;

    always_comb begin
        flags_d = flags_q;
        if (flag_we && FlagW[1]) begin
            flags_d[3:2] = ALUFlags[3:2];
        end
        if (flag_we && FlagW[0]) begin
            flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q  <= 4'b0000;
            it_err_q <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            it_err_q <= it_err_d;
        end
    end

    assign CondEx = cond_ex;
    assign Flags  = flags_q;
    assign ItErr  = it_err_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit. The driver applies directed vectors and
// pushes the hand-computed expectation for each cycle. The monitor pops and
// compares on the falling edge. Expectation word: {mask[9:0], value[9:0]},
// where value = {CondEx, Flags[3:0], InIt, ItRemaining[2:0], ItErr}.

module tb_cond_unit;

  localparam int IT_DEPTH = 4;
  localparam int LEN_W    = 3;

  localparam logic [9:0] M_CE  = 10'h200;
  localparam logic [9:0] M_FL  = 10'h1E0;
  localparam logic [9:0] M_ALL = 10'h3FF;

`ifdef COND_IT_EN
  localparam logic IT_BUILD = 1'b1;
`else
  localparam logic IT_BUILD = 1'b0;
`endif

  logic                clk;
  logic                reset_n;
  logic                InstrValid;
  logic [3:0]          Cond;
  logic [3:0]          ALUFlags;
  logic [1:0]          FlagW;
  logic                ItStart;
  logic [3:0]          ItCond;
  logic [LEN_W-1:0]    ItLen;
  logic [IT_DEPTH-1:0] ItPattern;
  logic                CondEx;
  logic [3:0]          Flags;
  logic                InIt;
  logic [LEN_W-1:0]    ItRemaining;
  logic                ItErr;

  cond_unit #(.IT_DEPTH(IT_DEPTH), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .InstrValid  (InstrValid),
    .Cond        (Cond),
    .ALUFlags    (ALUFlags),
    .FlagW       (FlagW),
    .ItStart     (ItStart),
    .ItCond      (ItCond),
    .ItLen       (ItLen),
    .ItPattern   (ItPattern),
    .CondEx      (CondEx),
    .Flags       (Flags),
    .InIt        (InIt),
    .ItRemaining (ItRemaining),
    .ItErr       (ItErr)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  // Hand-derived truth tables: bit f is CondEx for Flags = f ({N,Z,C,V}).
  logic [15:0] dec_tbl [16];
  initial begin
    dec_tbl = '{16'hF0F0, 16'h0F0F, 16'hCCCC, 16'h3333,
                16'hFF00, 16'h00FF, 16'hAAAA, 16'h5555,
                16'h0C0C, 16'hF3F3, 16'hAA55, 16'h55AA,
                16'h0A05, 16'hF5FA, 16'hFFFF, 16'h0000};
  end

  function automatic logic [9:0] ev(input logic ce, input logic [3:0] fl, input logic in_it,
                                    input logic [2:0] rm, input logic er);
    return {ce, fl, in_it, rm, er};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [19:0] e;
      logic [9:0]  act;
      e   = exp_q.pop_front();
      act = {CondEx, Flags, InIt, ItRemaining, ItErr};
      n_vec++;
      if ((act & e[19:10]) !== (e[9:0] & e[19:10])) begin
        n_miss++;
        $display("FAIL vec%0d @%0t: {CondEx,Flags,InIt,ItRem,ItErr} got=%b want=%b mask=%b",
                 n_vec, $time, act, e[9:0], e[19:10]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic v, input logic [3:0] c, input logic [3:0] alu,
                        input logic [1:0] fw);
    InstrValid = v;
    Cond       = c;
    ALUFlags   = alu;
    FlagW      = fw;
  endtask

  task automatic chk(input logic [9:0] m, input logic [9:0] v);
    exp_q.push_back({m, v});
    @(posedge clk);
    #1;
  endtask

  task automatic skip();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; ItStart = 1'b0; ItCond = 4'h0; ItLen = '0; ItPattern = '0;
    set_in(1'b0, 4'h0, 4'h0, 2'b00);
    skip();
    skip();
    reset_n = 1'b1;

    // Reset state, EQ false on cleared flags.
    set_in(1'b1, 4'b0000, 4'h0, 2'b00);   chk(M_ALL, ev(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0));
    // AL write of N,Z = 01.
    set_in(1'b1, 4'b1110, 4'b0100, 2'b10); chk(M_ALL, ev(1'b1, 4'b0000, 1'b0, 3'd0, 1'b0));
    // Visible next cycle; EQ now true.
    set_in(1'b1, 4'b0000, 4'h0, 2'b00);   chk(M_ALL, ev(1'b1, 4'b0100, 1'b0, 3'd0, 1'b0));
    // Clear flags, then a write under a failing EQ is suppressed.
    set_in(1'b1, 4'b1110, 4'b0000, 2'b10); chk(M_ALL, ev(1'b1, 4'b0100, 1'b0, 3'd0, 1'b0));
    set_in(1'b1, 4'b0000, 4'b1111, 2'b11); chk(M_ALL, ev(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0));
    // Partial writes: C,V only, then N,Z only.
    set_in(1'b1, 4'b1110, 4'b1111, 2'b01); chk(M_ALL, ev(1'b1, 4'b0000, 1'b0, 3'd0, 1'b0));
    set_in(1'b1, 4'b1110, 4'b1000, 2'b10); chk(M_ALL, ev(1'b1, 4'b0011, 1'b0, 3'd0, 1'b0));
    // InstrValid low blocks a write.
    set_in(1'b0, 4'b1110, 4'b0000, 2'b11); chk(M_ALL, ev(1'b1, 4'b1011, 1'b0, 3'd0, 1'b0));
    set_in(1'b0, 4'b1011, 4'b0000, 2'b00); chk(M_ALL, ev(1'b0, 4'b1011, 1'b0, 3'd0, 1'b0));

    // Full sweep: every code against every flag value.
    for (int f = 0; f < 16; f++) begin
      set_in(1'b1, 4'b1110, f[3:0], 2'b11);
      chk(M_CE, ev(1'b1, 4'h0, 1'b0, 3'd0, 1'b0));
      for (int c = 0; c < 16; c++) begin
        logic [15:0] row;
        row = dec_tbl[c];
        set_in(1'b0, c[3:0], 4'h0, 2'b00);
        chk(M_CE | M_FL, ev(row[f], f[3:0], 1'b0, 3'd0, 1'b0));
      end
    end

    // Set Flags = 0100 (Z) for the rest of the run.
    set_in(1'b1, 4'b1110, 4'b0100, 2'b11); chk(M_CE, ev(1'b1, 4'h0, 1'b0, 3'd0, 1'b0));

    // Illegal IT request (ItLen = 0): no flag write, one-cycle ItErr pulse.
    set_in(1'b1, 4'b1110, 4'b1011, 2'b11); ItStart = 1'b1; ItLen = 3'd0;
    chk(M_ALL, ev(IT_BUILD, 4'b0100, 1'b0, 3'd0, 1'b0));
    ItStart = 1'b0;
    set_in(1'b0, 4'b1110, 4'h0, 2'b00);   chk(M_ALL, ev(1'b1, 4'b0100, 1'b0, 3'd0, 1'b1));
    set_in(1'b0, 4'b1110, 4'h0, 2'b00);   chk(M_ALL, ev(1'b1, 4'b0100, 1'b0, 3'd0, 1'b0));

`ifdef COND_IT_EN
    // ItLen above IT_DEPTH is illegal and does not start a block.
    set_in(1'b1, 4'b1110, 4'h0, 2'b00); ItStart = 1'b1; ItCond = 4'b0000; ItLen = 3'd5;
    chk(M_ALL, ev(1'b1, 4'b0100, 1'b0, 3'd0, 1'b0));
    ItStart = 1'b0;
    chk(M_ALL, ev(1'b1, 4'b0100, 1'b0, 3'd0, 1'b1));

    // EQ block, pattern 101, Z = 1: CondEx 1,0,1 with ItRemaining 3,2,1.
    ItStart = 1'b1; ItCond = 4'b0000; ItLen = 3'd3; ItPattern = 4'b0101;
    set_in(1'b1, 4'b1110, 4'h0, 2'b00); chk(M_ALL, ev(1'b1, 4'b0100, 1'b0, 3'd0, 1'b0));
    ItStart = 1'b0;
    set_in(1'b1, 4'b1111, 4'h0, 2'b00);   chk(M_ALL, ev(1'b1, 4'b0100, 1'b1, 3'd3, 1'b0));
    set_in(1'b1, 4'b1110, 4'b0000, 2'b11); chk(M_ALL, ev(1'b0, 4'b0100, 1'b1, 3'd2, 1'b0));
    set_in(1'b1, 4'b1111, 4'h0, 2'b00);   chk(M_ALL, ev(1'b1, 4'b0100, 1'b1, 3'd1, 1'b0));
    set_in(1'b1, 4'b1111, 4'h0, 2'b00);   chk(M_ALL, ev(1'b0, 4'b0100, 1'b0, 3'd0, 1'b0));

    // InstrValid low for 3 cycles mid-block: hold, no flag write.
    ItStart = 1'b1; ItCond = 4'b0000; ItLen = 3'd2; ItPattern = 4'b0011;
    set_in(1'b1, 4'b1110, 4'h0, 2'b00); chk(M_ALL, ev(1'b1, 4'b0100, 1'b0, 3'd0, 1'b0));
    ItStart = 1'b0;
    set_in(1'b1, 4'b1111, 4'h0, 2'b00); chk(M_ALL, ev(1'b1, 4'b0100, 1'b1, 3'd2, 1'b0));
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 4'b1111, 4'b0000, 2'b11); chk(M_ALL, ev(1'b1, 4'b0100, 1'b1, 3'd1, 1'b0));
    end
    set_in(1'b1, 4'b1111, 4'h0, 2'b00); chk(M_ALL, ev(1'b1, 4'b0100, 1'b1, 3'd1, 1'b0));
    set_in(1'b0, 4'b1111, 4'h0, 2'b00); chk(M_ALL, ev(1'b0, 4'b0100, 1'b0, 3'd0, 1'b0));

    // Nested ItStart: error pulse, no flag write, slot consumed.
    ItStart = 1'b1; ItCond = 4'b0000; ItLen = 3'd3; ItPattern = 4'b0111;
    set_in(1'b1, 4'b1110, 4'h0, 2'b00); chk(M_ALL, ev(1'b1, 4'b0100, 1'b0, 3'd0, 1'b0));
    ItLen = 3'd2;
    set_in(1'b1, 4'b1110, 4'b0000, 2'b11); chk(M_ALL, ev(1'b1, 4'b0100, 1'b1, 3'd3, 1'b0));
    ItStart = 1'b0;
    set_in(1'b1, 4'b1111, 4'h0, 2'b00); chk(M_ALL, ev(1'b1, 4'b0100, 1'b1, 3'd2, 1'b1));
    set_in(1'b1, 4'b1111, 4'h0, 2'b00); chk(M_ALL, ev(1'b1, 4'b0100, 1'b1, 3'd1, 1'b0));
    set_in(1'b0, 4'b1111, 4'h0, 2'b00); chk(M_ALL, ev(1'b0, 4'b0100, 1'b0, 3'd0, 1'b0));

    // Reset while ItRemaining = 2 aborts the block.
    ItStart = 1'b1; ItCond = 4'b0000; ItLen = 3'd3; ItPattern = 4'b0111;
    set_in(1'b1, 4'b1110, 4'h0, 2'b00); chk(M_ALL, ev(1'b1, 4'b0100, 1'b0, 3'd0, 1'b0));
    ItStart = 1'b0;
    set_in(1'b1, 4'b1111, 4'h0, 2'b00); chk(M_ALL, ev(1'b1, 4'b0100, 1'b1, 3'd3, 1'b0));
    reset_n = 1'b0;
    set_in(1'b1, 4'b1111, 4'h0, 2'b00); chk(M_ALL, ev(1'b1, 4'b0100, 1'b1, 3'd2, 1'b0));
    reset_n = 1'b1;
    set_in(1'b0, 4'b0000, 4'h0, 2'b00); chk(M_ALL, ev(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0));
    set_in(1'b1, 4'b1110, 4'b0100, 2'b11); chk(M_CE, ev(1'b1, 4'h0, 1'b0, 3'd0, 1'b0));
`endif

    // Reset clears flags; the reset cycle still decodes the old flags.
    reset_n = 1'b0;
    set_in(1'b1, 4'b0000, 4'b1111, 2'b11); chk(M_ALL, ev(1'b1, 4'b0100, 1'b0, 3'd0, 1'b0));
    reset_n = 1'b1;
    set_in(1'b0, 4'b0000, 4'h0, 2'b00);   chk(M_ALL, ev(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0));

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) skip();
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
